// File: rtl/alu_8_driver_if.sv
// Command, ALU and response signal bundle for alu_8_driver.
// The slave modport is the driver side; master is its environment.
interface alu_8_driver_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic       alu_stb;
    logic [4:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [4:0] rsp_data;
    logic [2:0] rsp_op;
    logic       rsp_err;
    logic       busy;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op,
        output alu_result, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, alu_stb,
        input  rsp_valid, rsp_data, rsp_op, rsp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op,
        input  alu_result, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, alu_stb,
        output rsp_valid, rsp_data, rsp_op, rsp_err, busy
    );
endinterface

// File: rtl/alu_8_driver.sv
// Command FIFO plus issue/wait/hold sequencer in front of the 4-bit ALU.
// One command in flight; divide/modulo by zero is flagged at capture.
module alu_8_driver #(
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    alu_8_driver_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [10:0] mem_q [DEPTH];
    logic [AW:0] wptr_q, rptr_q;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  a_q, a_d, b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  data_q, data_d;
    logic [2:0]  rop_q, rop_d;
    logic        err_q, err_d;
    logic        full, empty, push, pop;
    logic        capture, zdiv, stb, rvalid;
    logic [10:0] head;

    // Wrap bits differ with equal addresses only when full.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push  = bus.cmd_valid && bus.cmd_ready;
    assign head  = mem_q[rptr_q[AW-1:0]];
    assign zdiv  = ((op_q == 3'b011) || (op_q == 3'b100)) &&
                   (b_q == 4'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
            if (pop)  rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                cnt_d   = 4'(LAT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) state_d = S_HOLD;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_HOLD: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop     = (state_q == S_IDLE) && !empty;
        stb     = (state_q == S_ISSUE);
        capture = (state_q == S_WAIT) && (cnt_q == 4'd1);
        rvalid  = (state_q == S_HOLD);
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        data_d = data_q;
        rop_d  = rop_q;
        err_d  = err_q;
        if (pop) {a_d, b_d, op_d} = head;
        if (capture) begin
            rop_d = op_q;
            if (zdiv) begin
                data_d = 5'b11111;
                err_d  = 1'b1;
            end else begin
                data_d = bus.alu_result;
                err_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            data_q <= '0;
            rop_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            data_q <= data_d;
            rop_q  <= rop_d;
            err_q  <= err_d;
        end
    end

    assign bus.cmd_ready = !full && !rst;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_sel   = op_q;
    assign bus.alu_stb   = stb;
    assign bus.rsp_valid = rvalid;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_op    = rop_q;
    assign bus.rsp_err   = err_q;
    assign bus.busy      = (state_q != S_IDLE) || !empty;
endmodule

// File: tb/tb_alu_8_driver.sv
// Directed bench for alu_8_driver with LAT=1, DEPTH=4.
// A small behavioural ALU answers from the held operands.
module tb_alu_8_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    alu_8_driver_if bus ();

    alu_8_driver #(.LAT(1), .DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Divide/modulo by zero returns a marker the driver must ignore.
    always_comb begin
        bus.alu_result = 5'd0;
        case (bus.alu_sel)
            3'd0: bus.alu_result = {1'b0, bus.alu_a};
            3'd1: bus.alu_result = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            3'd2: bus.alu_result = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            3'd3: bus.alu_result = (bus.alu_b == 0) ? 5'h0a :
                                   {1'b0, bus.alu_a / bus.alu_b};
            3'd4: bus.alu_result = (bus.alu_b == 0) ? 5'h0a :
                                   {1'b0, bus.alu_a % bus.alu_b};
            3'd5: bus.alu_result = {bus.alu_a, 1'b0};
            3'd6: bus.alu_result = {2'b0, bus.alu_a[3:1]};
            3'd7: bus.alu_result = {4'd0, bus.alu_a > bus.alu_b};
            default: bus.alu_result = 5'd0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op);
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !bus.cmd_ready; i++) tick();
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_stb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.alu_stb) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [24:0] outs;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got=%0b exp=0", bus.cmd_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready got=%0b exp=1",
                     bus.cmd_ready);
        end
        outs = {bus.alu_a, bus.alu_b, bus.alu_sel, bus.alu_stb,
                bus.rsp_valid, bus.rsp_data, bus.rsp_op, bus.rsp_err,
                bus.busy};
        checks++;
        if (outs !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", outs);
        end
    endtask

    task automatic test_single_add();
        send(4'd7, 4'd9, 3'b001);
        checks++;
        if (bus.alu_stb !== 1'b0) begin
            errors++;
            $display("FAIL add_stb_c1 got=%0b exp=0", bus.alu_stb);
        end
        tick();
        checks++;
        if ({bus.alu_stb, bus.alu_a, bus.alu_b, bus.alu_sel} !==
            {1'b1, 4'd7, 4'd9, 3'b001}) begin
            errors++;
            $display("FAIL add_issue_c2 got=%b,%0d,%0d,%0d exp=1,7,9,1",
                     bus.alu_stb, bus.alu_a, bus.alu_b, bus.alu_sel);
        end
        tick();
        checks++;
        if ({bus.alu_stb, bus.rsp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL add_c3 got=%b exp=00",
                     {bus.alu_stb, bus.rsp_valid});
        end
        tick();
        checks++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_op, bus.rsp_err} !==
            {1'b1, 5'd16, 3'b001, 1'b0}) begin
            errors++;
            $display("FAIL add_rsp_c4 got=%b,%0d,%0d,%b exp=1,16,1,0",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_op,
                     bus.rsp_err);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_after_hs got=%b exp=0", bus.rsp_valid);
        end
    endtask

    task automatic test_zero_div(input logic [2:0] op);
        bit ok;
        send(4'd5, 4'd0, op);
        wait_stb(ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL zdiv_stb op=%0d got=none exp=strobe", op);
        end
        wait_rsp(ok);
        checks++;
        if ({ok, bus.rsp_data, bus.rsp_op, bus.rsp_err} !==
            {1'b1, 5'h1f, op, 1'b1}) begin
            errors++;
            $display("FAIL zdiv_rsp op=%0d got=%b,%h,%0d,%b exp=1,1f,%0d,1",
                     op, ok, bus.rsp_data, bus.rsp_op, bus.rsp_err, op);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_fifo_full();
        int  pushed = 0;
        int  got = 0;
        bit  acc;
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_a = 4'(pushed + 1);
            bus.cmd_b = 4'd0;
            bus.cmd_op = 3'b000;
            acc = bus.cmd_ready;
            tick();
            if (acc) pushed++;
        end
        checks++;
        if ({pushed, bus.cmd_ready} !== {32'd5, 1'b0}) begin
            errors++;
            $display("FAIL fifo_full got=%0d,%b exp=5,0",
                     pushed, bus.cmd_ready);
        end
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 200 && got < 10; c++) begin
            bus.cmd_valid = (pushed < 10);
            bus.cmd_a = 4'(pushed + 1);
            acc = bus.cmd_valid && bus.cmd_ready;
            if (bus.rsp_valid) begin
                checks++;
                if (bus.rsp_data !== 5'(got + 1)) begin
                    errors++;
                    $display("FAIL fifo_order got=%0d exp=%0d",
                             bus.rsp_data, got + 1);
                end
                got++;
            end
            tick();
            if (acc) pushed++;
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        checks++;
        if (got !== 10) begin
            errors++;
            $display("FAIL fifo_count got=%0d exp=10", got);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        send(4'd3, 4'd4, 3'b001);
        send(4'd8, 4'd3, 3'b010);
        wait_rsp(ok);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({ok, bus.rsp_valid, bus.rsp_data, bus.alu_stb} !==
                {1'b1, 1'b1, 5'd7, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold c=%0d got=%b,%b,%0d,%b exp=1,1,7,0",
                         c, ok, bus.rsp_valid, bus.rsp_data, bus.alu_stb);
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.alu_stb !== 1'b0) begin
            errors++;
            $display("FAIL bp_stb_early got=%b exp=0", bus.alu_stb);
        end
        tick();
        checks++;
        if (bus.alu_stb !== 1'b1) begin
            errors++;
            $display("FAIL bp_stb_after got=%b exp=1", bus.alu_stb);
        end
        wait_rsp(ok);
        checks++;
        if ({ok, bus.rsp_data, bus.rsp_op} !== {1'b1, 5'd5, 3'b010}) begin
            errors++;
            $display("FAIL bp_second got=%b,%0d,%0d exp=1,5,2",
                     ok, bus.rsp_data, bus.rsp_op);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] ta [3] = '{4'd9, 4'd9, 4'd3};
        logic [3:0] tb [3] = '{4'd0, 4'd0, 4'd2};
        logic [2:0] to [3] = '{3'd5, 3'd6, 3'd7};
        logic [4:0] te [3] = '{5'd18, 5'd4, 5'd1};
        int  stb_at [3] = '{0, 0, 0};
        int  np = 0;
        int  nr = 0;
        int  ns = 0;
        bit  acc;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 60 && nr < 3; c++) begin
            bus.cmd_valid = (np < 3);
            if (np < 3) begin
                bus.cmd_a = ta[np];
                bus.cmd_b = tb[np];
                bus.cmd_op = to[np];
            end
            acc = bus.cmd_valid && bus.cmd_ready;
            if (bus.alu_stb && ns < 3) begin
                stb_at[ns] = c;
                ns++;
            end
            if (bus.rsp_valid) begin
                checks++;
                if ({bus.rsp_data, bus.rsp_op} !== {te[nr], to[nr]}) begin
                    errors++;
                    $display("FAIL b2b_rsp n=%0d got=%0d,%0d exp=%0d,%0d",
                             nr, bus.rsp_data, bus.rsp_op, te[nr], to[nr]);
                end
                nr++;
            end
            tick();
            if (acc) np++;
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        checks++;
        if ({nr, stb_at[1] - stb_at[0], stb_at[2] - stb_at[1]} !==
            {32'd3, 32'd4, 32'd4}) begin
            errors++;
            $display("FAIL b2b_rate got=%0d,%0d,%0d exp=3,4,4", nr,
                     stb_at[1] - stb_at[0], stb_at[2] - stb_at[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [25:0] outs;
        bit          seen;
        bus.rsp_ready = 1'b0;
        send(4'd1, 4'd1, 3'b001);
        send(4'd2, 4'd2, 3'b001);
        send(4'd3, 4'd3, 3'b001);
        checks++;
        if ({bus.busy, bus.rsp_valid, bus.alu_stb} !== 3'b100) begin
            errors++;
            $display("FAIL mid_wait got=%b exp=100",
                     {bus.busy, bus.rsp_valid, bus.alu_stb});
        end
        rst = 1'b1;
        tick();
        outs = {bus.cmd_ready, bus.alu_a, bus.alu_b, bus.alu_sel,
                bus.alu_stb, bus.rsp_valid, bus.rsp_data, bus.rsp_op,
                bus.rsp_err, bus.busy};
        checks++;
        if (outs !== 26'd0) begin
            errors++;
            $display("FAIL mid_reset_outs got=%h exp=0", outs);
        end
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.rsp_valid || bus.alu_stb || bus.busy) seen = 1'b1;
            tick();
        end
        bus.rsp_ready = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_discard got=activity exp=none");
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = 4'd0;
        bus.cmd_b     = 4'd0;
        bus.cmd_op    = 3'd0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single_add();
        test_zero_div(3'b011);
        test_zero_div(3'b100);
        test_fifo_full();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
